// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the control FSM and the MULT/DIV unit.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic                    Start;
    logic                    DivMult;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH-1:0] HiOut;
    logic signed [WIDTH-1:0] LoOut;
    logic                    Busy;
    logic                    Done;
    logic                    DivZero;

    modport master (
        output Start, DivMult, A, B,
        input  HiOut, LoOut, Busy, Done, DivZero
    );

    modport slave (
        input  Start, DivMult, A, B,
        output HiOut, LoOut, Busy, Done, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring, sign-magnitude) unit.
// One iteration per clock, WIDTH iterations, then a single sign-fixup cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    mult_div_if.slave  bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic                    op_div;
    logic                    div_zero_flag;
    logic signed [WIDTH-1:0] a_lat;
    logic signed [WIDTH-1:0] b_lat;

    // acc doubles as the Booth accumulator and the division remainder;
    // q_reg doubles as the multiplier and the dividend/quotient shift register.
    logic signed [WIDTH:0]   acc;
    logic [WIDTH-1:0]        q_reg;
    logic                    q_m1;

    logic signed [WIDTH-1:0] hi_out;
    logic signed [WIDTH-1:0] lo_out;

    logic signed [WIDTH:0]   a_ext;
    logic signed [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0]        b_mag;
    logic [WIDTH:0]          div_shift;
    logic [WIDTH:0]          div_trial;
    logic                    start_div_zero;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // |-2^(WIDTH-1)| comes out as 2^(WIDTH-1), which is exact as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? twos_neg(v) : v;
    endfunction

    assign start_div_zero = bus.DivMult && (bus.B == '0);

    assign a_ext     = {a_lat[WIDTH-1], a_lat};
    assign b_mag     = abs_mag(b_lat);
    assign div_shift = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_mag};

    always_comb begin
        booth_sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   booth_sum = acc + a_ext;
            2'b10:   booth_sum = acc - a_ext;
            default: booth_sum = acc;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_next = start_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CNT_LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy    = (state == RUN) || (state == FIX);
        bus.Done    = (state == DONE);
        bus.DivZero = (state == DONE) && div_zero_flag;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count         <= '0;
            op_div        <= 1'b0;
            div_zero_flag <= 1'b0;
            a_lat         <= '0;
            b_lat         <= '0;
            acc           <= '0;
            q_reg         <= '0;
            q_m1          <= 1'b0;
            hi_out        <= '0;
            lo_out        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a_lat         <= bus.A;
                        b_lat         <= bus.B;
                        op_div        <= bus.DivMult;
                        div_zero_flag <= start_div_zero;
                        count         <= '0;
                        acc           <= '0;
                        q_reg         <= bus.DivMult ? abs_mag(bus.A) : bus.B;
                        q_m1          <= 1'b0;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (op_div) begin
                        // A negative trial means |B| did not fit: keep the shifted remainder.
                        if (!div_trial[WIDTH]) begin
                            acc   <= div_trial;
                            q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc   <= div_shift;
                            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc   <= booth_sum >>> 1;
                        q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
                        q_m1  <= q_reg[0];
                    end
                end
                FIX: begin
                    if (op_div) begin
                        lo_out <= (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) ? twos_neg(q_reg) : q_reg;
                        hi_out <= a_lat[WIDTH-1] ? twos_neg(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                    end else begin
                        hi_out <= acc[WIDTH-1:0];
                        lo_out <= q_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.HiOut = hi_out;
    assign bus.LoOut = lo_out;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed table plus multi-cycle corner sequences and a model-checked random sweep.
module tb_mult_div_unit;
    logic Clock = 1'b0;
    logic Reset;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int lat);
        while (bus.Done !== 1'b1 && lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
        end
    endtask

    // Called at #1 after a posedge; returns in the Done cycle with lat counting the Start cycle.
    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        bus.Start   = 1'b1;
        bus.DivMult = op;
        bus.A       = a;
        bus.B       = b;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        lat = 1;
        wait_done(lat);
    endtask

    task automatic finish_op();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int          lat;
        int          done_cnt;
        logic [31:0] ra, rb;
        logic        rop;
        longint      sa, sb, prod, quo, rem;
        logic [63:0] pbits;

        vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[3]  = '{1'b0, 32'h00010000,  32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 34};
        vecs[4]  = '{1'b0, 32'h7FFFFFFF,  32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[6]  = '{1'b1, 32'd100,       32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[7]  = '{1'b1, 32'd5,         32'd0,        32'd2,        32'd14,       1'b1, 1};
        vecs[8]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[9]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
        vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, 34};
        vecs[11] = '{1'b1, 32'd3,         32'd5,        32'd3,        32'd0,        1'b0, 34};
        vecs[12] = '{1'b1, 32'h80000000,  32'd1,        32'd0,        32'h80000000, 1'b0, 34};
        vecs[13] = '{1'b1, 32'd0,         32'd0,        32'd0,        32'h80000000, 1'b1, 1};

        Reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.DivMult = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_hi",   bus.HiOut,   32'd0);
        check("reset_lo",   bus.LoOut,   32'd0);
        check("reset_busy", {31'd0, bus.Busy},    32'd0);
        check("reset_done", {31'd0, bus.Done},    32'd0);
        check("reset_dz",   {31'd0, bus.DivZero}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_hi", i),  bus.HiOut, vecs[i].hi);
            check($sformatf("vec%0d_lo", i),  bus.LoOut, vecs[i].lo);
            check($sformatf("vec%0d_dz", i),  {31'd0, bus.DivZero}, {31'd0, vecs[i].dz});
            finish_op();
        end

        // Second Start mid-run is ignored; operand changes after Start do not matter.
        bus.Start = 1'b1; bus.DivMult = 1'b0; bus.A = 32'd7; bus.B = 32'hFFFFFFFD;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        bus.Start = 1'b1; bus.DivMult = 1'b1; bus.A = 32'd100; bus.B = 32'd7;
        check("ign_busy_run", {31'd0, bus.Busy}, 32'd1);
        @(posedge Clock);
        #1;
        lat++;
        bus.Start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 32'd34);
        check("ign_hi",  bus.HiOut, 32'hFFFFFFFF);
        check("ign_lo",  bus.LoOut, 32'hFFFFFFEB);
        check("done_busy", {31'd0, bus.Busy}, 32'd0);

        // Start held through DONE: ignored there, accepted in the following IDLE cycle.
        bus.Start = 1'b1;
        @(posedge Clock);
        #1;
        check("b2b_idle_done", {31'd0, bus.Done}, 32'd0);
        check("b2b_idle_busy", {31'd0, bus.Busy}, 32'd0);
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        check("b2b_run_busy", {31'd0, bus.Busy}, 32'd1);
        lat = 1;
        wait_done(lat);
        check("b2b_lat", lat, 32'd34);
        check("b2b_hi",  bus.HiOut, 32'd2);
        check("b2b_lo",  bus.LoOut, 32'd14);
        finish_op();

        // Reset in the middle of a run discards everything.
        bus.Start = 1'b1; bus.DivMult = 1'b0; bus.A = 32'd7; bus.B = 32'hFFFFFFFD;
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_mid_done", {31'd0, bus.Done}, 32'd0);
        check("rst_mid_hi",   bus.HiOut, 32'd0);
        check("rst_mid_lo",   bus.LoOut, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge Clock);
            #1;
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) done_cnt++;
        end
        check("rst_mid_quiet", done_cnt, 32'd0);

        for (int n = 0; n < 200; n++) begin
            rop = n[0];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h7FFFFFFF;
                3: rb = $urandom_range(1, 20);
                default: begin
                end
            endcase
            if (rb == 32'd0) rb = 32'd3;
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            start_op(rop, ra, rb, lat);
            check($sformatf("rnd%0d_lat", n), lat, 32'd34);
            if (rop) begin
                quo = sa / sb;
                rem = sa % sb;
                check($sformatf("rnd%0d_div_hi a=%h b=%h", n, ra, rb), bus.HiOut, rem[31:0]);
                check($sformatf("rnd%0d_div_lo a=%h b=%h", n, ra, rb), bus.LoOut, quo[31:0]);
            end else begin
                prod  = sa * sb;
                pbits = prod;
                check($sformatf("rnd%0d_mul_hi a=%h b=%h", n, ra, rb), bus.HiOut, pbits[63:32]);
                check($sformatf("rnd%0d_mul_lo a=%h b=%h", n, ra, rb), bus.LoOut, pbits[31:0]);
            end
            finish_op();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
